// File: rtl/axi_ram_pkg.sv
// Shared AXI constants and controller state encoding for the axi_ram master/slave pair.
package axi_ram_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} axi_state_e;
endpackage

// File: rtl/axi_ram_mst_ctl.sv
// Single-request to AXI3 initiator: INCR read bursts of len+1 beats, single-beat writes.
// One transaction in flight; every output comes straight from a flop.
module axi_ram_mst_ctl
    import axi_ram_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'b0011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_wen,
    input  logic [31:0] io_req_adr,
    input  logic [3:0]  io_req_len,
    input  logic [31:0] io_req_wdat,
    input  logic [3:0]  io_req_wstrb,
    output logic        io_rsp_valid,
    output logic [31:0] io_rsp_rdat,
    output logic        io_rsp_last,
    output logic        io_rsp_err,
    input  logic        io_axi_slv_ar_chl_ready,
    output logic        io_axi_slv_ar_chl_valid,
    output logic [3:0]  io_axi_slv_ar_chl_bits_arid,
    output logic [31:0] io_axi_slv_ar_chl_bits_araddr,
    output logic [2:0]  io_axi_slv_ar_chl_bits_arsize,
    output logic [3:0]  io_axi_slv_ar_chl_bits_arlen,
    output logic [1:0]  io_axi_slv_ar_chl_bits_arbusrt,
    output logic [1:0]  io_axi_slv_ar_chl_bits_arlock,
    output logic [1:0]  io_axi_slv_ar_chl_bits_arcache,
    output logic [1:0]  io_axi_slv_ar_chl_bits_arprot,
    output logic        io_axi_slv_r_chl_ready,
    input  logic        io_axi_slv_r_chl_valid,
    input  logic [31:0] io_axi_slv_r_chl_bits_rdata,
    input  logic [3:0]  io_axi_slv_r_chl_bits_rid,
    input  logic [1:0]  io_axi_slv_r_chl_bits_rresp,
    input  logic        io_axi_slv_r_chl_bits_rlast,
    input  logic        io_axi_slv_aw_chl_ready,
    output logic        io_axi_slv_aw_chl_valid,
    output logic [3:0]  io_axi_slv_aw_chl_bits_awid,
    output logic [31:0] io_axi_slv_aw_chl_bits_awaddr,
    output logic [2:0]  io_axi_slv_aw_chl_bits_awsize,
    output logic [3:0]  io_axi_slv_aw_chl_bits_awlen,
    output logic [1:0]  io_axi_slv_aw_chl_bits_awbusrt,
    output logic [1:0]  io_axi_slv_aw_chl_bits_awlock,
    output logic [1:0]  io_axi_slv_aw_chl_bits_awcache,
    output logic [1:0]  io_axi_slv_aw_chl_bits_awprot,
    input  logic        io_axi_slv_w_chl_ready,
    output logic        io_axi_slv_w_chl_valid,
    output logic [31:0] io_axi_slv_w_chl_bits_wdata,
    output logic [3:0]  io_axi_slv_w_chl_bits_wid,
    output logic [3:0]  io_axi_slv_w_chl_bits_wstrb,
    output logic        io_axi_slv_w_chl_bits_wlast,
    output logic        io_axi_slv_b_chl_ready,
    input  logic        io_axi_slv_b_chl_valid,
    input  logic [3:0]  io_axi_slv_b_chl_bits_bid,
    input  logic [1:0]  io_axi_slv_b_chl_bits_bresp
);

    axi_state_e  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] adr_q, adr_d, wdat_q, wdat_d;
    logic [3:0]  len_q, len_d, wstrb_q, wstrb_d;
    logic [3:0]  id_q, id_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic        bready_q, bready_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdat_q, rsp_rdat_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        beat_err;

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        adr_d       = adr_q;
        len_d       = len_q;
        wdat_d      = wdat_q;
        wstrb_d     = wstrb_q;
        id_d        = id_q;
        size_d      = size_q;
        burst_d     = burst_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        bready_d    = bready_q;
        rsp_valid_d = 1'b0;
        rsp_rdat_d  = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        beat_err    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (io_req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    adr_d   = io_req_adr;
                    len_d   = io_req_len;
                    wdat_d  = io_req_wdat;
                    wstrb_d = io_req_wstrb;
                    id_d    = AXI_ID;
                    size_d  = AXI_SIZE_4B;
                    burst_d = AXI_BURST_INCR;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (io_req_wen) begin
                        state_d   = AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            AR: if (arvalid_q && io_axi_slv_ar_chl_ready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = R;
            end
            R: if (io_axi_slv_r_chl_valid && rready_q) begin
                // rlast must land exactly on beat len; early ends the burst, late keeps draining
                beat_err = (io_axi_slv_r_chl_bits_rresp != AXI_RESP_OKAY) ||
                           (io_axi_slv_r_chl_bits_rid != AXI_ID) ||
                           (io_axi_slv_r_chl_bits_rlast ? (cnt_q < len_q) : (cnt_q >= len_q));
                err_d       = err_q | beat_err;
                rsp_valid_d = 1'b1;
                rsp_rdat_d  = io_axi_slv_r_chl_bits_rdata;
                rsp_err_d   = err_d;
                if (cnt_q != 4'hF)
                    cnt_d = cnt_q + 4'd1;
                if (io_axi_slv_r_chl_bits_rlast) begin
                    rsp_last_d  = 1'b1;
                    rready_d    = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            AW: if (awvalid_q && io_axi_slv_aw_chl_ready) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                wlast_d   = 1'b1;
                state_d   = W;
            end
            W: if (wvalid_q && io_axi_slv_w_chl_ready) begin
                wvalid_d = 1'b0;
                wlast_d  = 1'b0;
                bready_d = 1'b1;
                state_d  = B;
            end
            B: if (io_axi_slv_b_chl_valid && bready_q) begin
                err_d = err_q || (io_axi_slv_b_chl_bits_bresp != AXI_RESP_OKAY) ||
                        (io_axi_slv_b_chl_bits_bid != AXI_ID);
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_err_d   = err_d;
                bready_d    = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            adr_q       <= '0;
            len_q       <= '0;
            wdat_q      <= '0;
            wstrb_q     <= '0;
            id_q        <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdat_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            adr_q       <= adr_d;
            len_q       <= len_d;
            wdat_q      <= wdat_d;
            wstrb_q     <= wstrb_d;
            id_q        <= id_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdat_q  <= rsp_rdat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign io_req_ready  = req_ready_q;
    assign io_rsp_valid  = rsp_valid_q;
    assign io_rsp_rdat   = rsp_rdat_q;
    assign io_rsp_last   = rsp_last_q;
    assign io_rsp_err    = rsp_err_q;

    assign io_axi_slv_ar_chl_valid        = arvalid_q;
    assign io_axi_slv_ar_chl_bits_arid    = id_q;
    assign io_axi_slv_ar_chl_bits_araddr  = adr_q;
    assign io_axi_slv_ar_chl_bits_arsize  = size_q;
    assign io_axi_slv_ar_chl_bits_arlen   = len_q;
    assign io_axi_slv_ar_chl_bits_arbusrt = burst_q;
    assign io_axi_slv_ar_chl_bits_arlock  = 2'b00;
    assign io_axi_slv_ar_chl_bits_arcache = 2'b00;
    assign io_axi_slv_ar_chl_bits_arprot  = 2'b00;
    assign io_axi_slv_r_chl_ready         = rready_q;

    assign io_axi_slv_aw_chl_valid        = awvalid_q;
    assign io_axi_slv_aw_chl_bits_awid    = id_q;
    assign io_axi_slv_aw_chl_bits_awaddr  = adr_q;
    assign io_axi_slv_aw_chl_bits_awsize  = size_q;
    assign io_axi_slv_aw_chl_bits_awlen   = 4'd0;
    assign io_axi_slv_aw_chl_bits_awbusrt = burst_q;
    assign io_axi_slv_aw_chl_bits_awlock  = 2'b00;
    assign io_axi_slv_aw_chl_bits_awcache = 2'b00;
    assign io_axi_slv_aw_chl_bits_awprot  = 2'b00;

    assign io_axi_slv_w_chl_valid         = wvalid_q;
    assign io_axi_slv_w_chl_bits_wdata    = wdat_q;
    assign io_axi_slv_w_chl_bits_wid      = id_q;
    assign io_axi_slv_w_chl_bits_wstrb    = wstrb_q;
    assign io_axi_slv_w_chl_bits_wlast    = wlast_q;
    assign io_axi_slv_b_chl_ready         = bready_q;

endmodule

// File: tb/tb_axi_ram_mst_ctl.sv
// Scoreboard bench for axi_ram_mst_ctl: behavioural AXI slave, expected responses queued at issue.
module tb_axi_ram_mst_ctl;
    localparam logic [3:0] ID = 4'b0011;

    logic        clock, reset;
    logic        io_req_valid, io_req_ready, io_req_wen;
    logic [31:0] io_req_adr, io_req_wdat;
    logic [3:0]  io_req_len, io_req_wstrb;
    logic        io_rsp_valid, io_rsp_last, io_rsp_err;
    logic [31:0] io_rsp_rdat;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_id, ar_len;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst, ar_lock, ar_cache, ar_prot;
    logic        r_ready, r_valid, r_last;
    logic [31:0] r_data;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic        aw_ready, aw_valid;
    logic [3:0]  aw_id, aw_len;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst, aw_lock, aw_cache, aw_prot;
    logic        w_ready, w_valid, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_id, w_strb;
    logic        b_ready, b_valid;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    axi_ram_mst_ctl dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_wen(io_req_wen),
        .io_req_adr(io_req_adr), .io_req_len(io_req_len), .io_req_wdat(io_req_wdat),
        .io_req_wstrb(io_req_wstrb),
        .io_rsp_valid(io_rsp_valid), .io_rsp_rdat(io_rsp_rdat), .io_rsp_last(io_rsp_last),
        .io_rsp_err(io_rsp_err),
        .io_axi_slv_ar_chl_ready(ar_ready), .io_axi_slv_ar_chl_valid(ar_valid),
        .io_axi_slv_ar_chl_bits_arid(ar_id), .io_axi_slv_ar_chl_bits_araddr(ar_addr),
        .io_axi_slv_ar_chl_bits_arsize(ar_size), .io_axi_slv_ar_chl_bits_arlen(ar_len),
        .io_axi_slv_ar_chl_bits_arbusrt(ar_burst), .io_axi_slv_ar_chl_bits_arlock(ar_lock),
        .io_axi_slv_ar_chl_bits_arcache(ar_cache), .io_axi_slv_ar_chl_bits_arprot(ar_prot),
        .io_axi_slv_r_chl_ready(r_ready), .io_axi_slv_r_chl_valid(r_valid),
        .io_axi_slv_r_chl_bits_rdata(r_data), .io_axi_slv_r_chl_bits_rid(r_id),
        .io_axi_slv_r_chl_bits_rresp(r_resp), .io_axi_slv_r_chl_bits_rlast(r_last),
        .io_axi_slv_aw_chl_ready(aw_ready), .io_axi_slv_aw_chl_valid(aw_valid),
        .io_axi_slv_aw_chl_bits_awid(aw_id), .io_axi_slv_aw_chl_bits_awaddr(aw_addr),
        .io_axi_slv_aw_chl_bits_awsize(aw_size), .io_axi_slv_aw_chl_bits_awlen(aw_len),
        .io_axi_slv_aw_chl_bits_awbusrt(aw_burst), .io_axi_slv_aw_chl_bits_awlock(aw_lock),
        .io_axi_slv_aw_chl_bits_awcache(aw_cache), .io_axi_slv_aw_chl_bits_awprot(aw_prot),
        .io_axi_slv_w_chl_ready(w_ready), .io_axi_slv_w_chl_valid(w_valid),
        .io_axi_slv_w_chl_bits_wdata(w_data), .io_axi_slv_w_chl_bits_wid(w_id),
        .io_axi_slv_w_chl_bits_wstrb(w_strb), .io_axi_slv_w_chl_bits_wlast(w_last),
        .io_axi_slv_b_chl_ready(b_ready), .io_axi_slv_b_chl_valid(b_valid),
        .io_axi_slv_b_chl_bits_bid(b_id), .io_axi_slv_b_chl_bits_bresp(b_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  len;
        logic [31:0] wdat;
        logic [3:0]  wstrb;
        int          nret;   // beats the slave returns (rlast on the final one)
        int          rerr;   // beat index with rresp=SLVERR, -1 none
        int          ridb;   // beat index with a foreign rid, -1 none
        logic [1:0]  bresp;
        logic [3:0]  bid;
        int          stall;
    } txn_t;

    typedef struct {
        logic [31:0] rdat;
        logic        last;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tmo(string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    function automatic logic [31:0] rd_word(logic [31:0] adr, int k);
        return adr + 32'(k) * 32'd4;
    endfunction

    function automatic txn_t mk(logic wen, logic [31:0] adr, logic [3:0] len, logic [31:0] wdat,
                                logic [3:0] wstrb, int nret, int rerr, int ridb,
                                logic [1:0] bresp, logic [3:0] bid, int stall);
        txn_t t;
        t.wen = wen; t.adr = adr; t.len = len; t.wdat = wdat; t.wstrb = wstrb;
        t.nret = nret; t.rerr = rerr; t.ridb = ridb; t.bresp = bresp; t.bid = bid;
        t.stall = stall;
        return t;
    endfunction

    // Monitor: every response pulse is matched against the oldest queued expectation.
    always @(negedge clock) begin
        if (io_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: got rdat %0h with empty scoreboard", io_rsp_rdat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdat", 64'(io_rsp_rdat), 64'(e.rdat));
                chk("rsp_last", 64'(io_rsp_last), 64'(e.last));
                chk("rsp_err", 64'(io_rsp_err), 64'(e.err));
            end
        end
    end

    task automatic issue(txn_t t);
        int  to;
        logic e, last;
        to = 0;
        while (!io_req_ready) begin @(negedge clock); if (++to > 100) tmo("req_ready"); end
        io_req_valid = 1'b1; io_req_wen = t.wen; io_req_adr = t.adr; io_req_len = t.len;
        io_req_wdat = t.wdat; io_req_wstrb = t.wstrb;
        if (t.wen) begin
            exp_q.push_back('{32'h0, 1'b1, (t.bresp != 2'b00) || (t.bid != ID)});
        end else begin
            e = 1'b0;
            for (int k = 0; k < t.nret; k++) begin
                last = (k == t.nret - 1);
                e = e || (k == t.rerr) || (k == t.ridb) ||
                    (last && k < int'(t.len)) || (!last && k >= int'(t.len));
                exp_q.push_back('{rd_word(t.adr, k), last, e});
            end
        end
        @(negedge clock);
        io_req_valid = 1'b0;
        chk("req_ready_drop", 64'(io_req_ready), 64'(0));
    endtask

    task automatic serve(txn_t t);
        int to;
        logic [63:0] ar_exp, aw_exp, w_exp;
        ar_exp = {1'b1, t.adr, t.len, 3'd2, 2'b01, ID, 6'd0};
        aw_exp = {1'b1, t.adr, 4'd0, 3'd2, 2'b01, ID, 6'd0, 1'b0};
        w_exp  = {1'b1, t.wdat, t.wstrb, ID, 1'b1};
        if (!t.wen) begin
            to = 0;
            while (!ar_valid) begin @(negedge clock); if (++to > 100) tmo("arvalid"); end
            repeat (t.stall) begin
                chk("ar_hold", {ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_lock, ar_cache, ar_prot}, ar_exp);
                @(negedge clock);
            end
            chk("ar_bits", {ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_lock, ar_cache, ar_prot}, ar_exp);
            ar_ready = 1'b1;
            @(negedge clock);
            ar_ready = 1'b0;
            chk("ar_single", 64'(ar_valid), 64'(0));
            for (int k = 0; k < t.nret; k++) begin
                repeat ($urandom_range(0, 1)) @(negedge clock);
                r_valid = 1'b1; r_data = rd_word(t.adr, k); r_last = (k == t.nret - 1);
                r_resp = (k == t.rerr) ? 2'b10 : 2'b00;
                r_id   = (k == t.ridb) ? 4'h9 : ID;
                to = 0;
                while (!r_ready) begin @(negedge clock); if (++to > 100) tmo("rready"); end
                @(negedge clock);
                r_valid = 1'b0; r_last = 1'b0;
            end
        end else begin
            to = 0;
            while (!aw_valid) begin @(negedge clock); if (++to > 100) tmo("awvalid"); end
            repeat (t.stall) begin
                chk("aw_hold", {aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_lock, aw_cache, aw_prot, w_valid}, aw_exp);
                @(negedge clock);
            end
            chk("aw_bits", {aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_lock, aw_cache, aw_prot, w_valid}, aw_exp);
            aw_ready = 1'b1;
            @(negedge clock);
            aw_ready = 1'b0;
            chk("aw_single", 64'(aw_valid), 64'(0));
            to = 0;
            while (!w_valid) begin @(negedge clock); if (++to > 100) tmo("wvalid"); end
            repeat (t.stall) begin
                chk("w_hold", {w_valid, w_data, w_strb, w_id, w_last}, w_exp);
                @(negedge clock);
            end
            chk("w_bits", {w_valid, w_data, w_strb, w_id, w_last}, w_exp);
            w_ready = 1'b1;
            @(negedge clock);
            w_ready = 1'b0;
            chk("w_single", 64'(w_valid), 64'(0));
            repeat ($urandom_range(0, 2)) @(negedge clock);
            b_valid = 1'b1; b_resp = t.bresp; b_id = t.bid;
            to = 0;
            while (!b_ready) begin @(negedge clock); if (++to > 100) tmo("bready"); end
            @(negedge clock);
            b_valid = 1'b0;
        end
    endtask

    initial begin
        txn_t t;
        txn_t dir[$];
        int   m, to;
        reset = 1'b0; io_req_valid = 1'b0; io_req_wen = 1'b0; io_req_adr = '0; io_req_len = '0;
        io_req_wdat = '0; io_req_wstrb = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_id = '0; r_resp = '0; r_last = 1'b0;
        b_valid = 1'b0; b_id = '0; b_resp = '0;
        repeat (3) @(negedge clock);
        chk("reset_ctl", {io_req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, io_rsp_valid, io_rsp_last, io_rsp_err}, 64'(0));
        chk("reset_bits", {ar_addr, ar_size, ar_burst, ar_id, io_rsp_rdat}, 64'(0));
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 64'(io_req_ready), 64'(1));

        dir.push_back(mk(0, 32'h100, 4'd9, 0, 0, 10, -1, -1, 2'b00, ID, 0));
        dir.push_back(mk(1, 32'h40, 4'd0, 32'h3, 4'hF, 0, -1, -1, 2'b00, ID, 0));
        dir.push_back(mk(0, 32'h2000, 4'd2, 0, 0, 3, -1, -1, 2'b00, ID, 5));
        dir.push_back(mk(1, 32'h44, 4'd0, 32'hDEADBEEF, 4'h5, 0, -1, -1, 2'b00, ID, 5));
        dir.push_back(mk(0, 32'h300, 4'd3, 0, 0, 4, 2, -1, 2'b00, ID, 0));
        dir.push_back(mk(1, 32'h48, 4'd0, 32'h1234, 4'h3, 0, -1, -1, 2'b11, ID, 1));
        dir.push_back(mk(0, 32'h400, 4'd3, 0, 0, 2, -1, -1, 2'b00, ID, 0));
        dir.push_back(mk(0, 32'h500, 4'd3, 0, 0, 6, -1, -1, 2'b00, ID, 0));
        dir.push_back(mk(0, 32'h600, 4'd0, 0, 0, 1, -1, 0, 2'b00, ID, 0));
        dir.push_back(mk(1, 32'h4C, 4'd0, 32'h55, 4'h8, 0, -1, -1, 2'b00, 4'hC, 0));
        dir.push_back(mk(0, 32'h700, 4'd15, 0, 0, 18, -1, -1, 2'b00, ID, 2));
        foreach (dir[i]) begin
            issue(dir[i]);
            serve(dir[i]);
        end

        for (int i = 0; i < 40; i++) begin
            t = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)),
                   $urandom, 4'($urandom_range(0, 15)), 0, -1, -1, 2'b00, ID, $urandom_range(0, 5));
            t.nret = int'(t.len) + 1;
            m = $urandom_range(0, 5);
            if (m == 0 && t.len != 0) t.nret = $urandom_range(1, int'(t.len));
            else if (m == 1) t.nret = int'(t.len) + 1 + $urandom_range(1, 2);
            else if (m == 2) t.rerr = $urandom_range(0, int'(t.len));
            else if (m == 3) t.ridb = $urandom_range(0, int'(t.len));
            if ($urandom_range(0, 3) == 0) t.bresp = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) t.bid = 4'($urandom_range(4, 15));
            issue(t);
            serve(t);
        end

        // Reset lands while beat index 3 of a 10-beat read is on the bus.
        to = 0;
        while (!io_req_ready) begin @(negedge clock); if (++to > 100) tmo("req_ready_rst"); end
        io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_adr = 32'h800; io_req_len = 4'd9;
        @(negedge clock);
        io_req_valid = 1'b0;
        to = 0;
        while (!ar_valid) begin @(negedge clock); if (++to > 100) tmo("arvalid_rst"); end
        ar_ready = 1'b1;
        @(negedge clock);
        ar_ready = 1'b0;
        to = 0;
        while (!r_ready) begin @(negedge clock); if (++to > 100) tmo("rready_rst"); end
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1; r_data = rd_word(32'h800, k); r_id = ID; r_resp = 2'b00; r_last = 1'b0;
            if (k < 3) exp_q.push_back('{rd_word(32'h800, k), 1'b0, 1'b0});
            else reset = 1'b0;
            @(negedge clock);
        end
        r_valid = 1'b0;
        chk("mid_reset_ctl", {ar_valid, aw_valid, w_valid, r_ready, b_ready, io_rsp_valid, io_req_ready}, 64'(0));
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_mid_reset", 64'(io_req_ready), 64'(1));
        t = mk(0, 32'h900, 4'd1, 0, 0, 2, -1, -1, 2'b00, ID, 0);
        issue(t);
        serve(t);

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
